// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] CHECKSUM_INIT  = 8'h00;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs a little-endian byte stream into words; word_valid pulses with the last byte.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic [7:0]                  in_byte,
    output logic                        word_valid,
    output logic [BYTES_PER_WORD*8-1:0] word
);

    localparam int SH_W = (BYTES_PER_WORD - 1) * 8;

    logic [1:0]      r_cnt;
    logic [SH_W-1:0] r_sh;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_cnt <= '0;
            r_sh  <= '0;
        end else if (in_valid) begin
            r_cnt <= r_cnt + 2'd1;
            r_sh  <= {in_byte, r_sh[SH_W-1:8]};
        end
    end

    // The final byte completes the word combinationally so the top can register it.
    assign word_valid = in_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
    assign word       = {in_byte, r_sh};

endmodule

// File: rtl/prog_loader.sv
// Frame parser that writes ToyRISC program memory and holds the CPU until a good checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]        MAGIC     = MAGIC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t            r_state;
    state_t            w_next;
    logic              r_rx_ready;
    logic              r_pm_we;
    logic [ADDR_W-1:0] r_pm_addr;
    logic [DATA_W-1:0] r_pm_wdata;
    logic [15:0]       r_count;
    logic [15:0]       r_word_cnt;
    logic [7:0]        r_csum;

    logic              w_accept;
    logic              w_rearm;
    logic              w_word_valid;
    logic [DATA_W-1:0] w_word;
    logic [15:0]       w_count;

    assign w_accept = rx_valid && r_rx_ready;
    assign w_rearm  = start && (r_state == S_DONE || r_state == S_ERROR);
    assign w_count  = {rx_byte, r_count[7:0]};

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (r_state != S_DATA),
        .in_valid   (w_accept && (r_state == S_DATA)),
        .in_byte    (rx_byte),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && rx_byte == MAGIC) w_next = S_LEN_LO;
            S_LEN_LO: if (w_accept) w_next = S_LEN_HI;
            S_LEN_HI: begin
                if (w_accept) begin
                    if (w_count == 16'd0)             w_next = S_CHECK;
                    else if (w_count > 16'(DEPTH))    w_next = S_ERROR;
                    else                              w_next = S_DATA;
                end
            end
            S_DATA:   if (w_word_valid && r_word_cnt == r_count - 16'd1) w_next = S_CHECK;
            S_CHECK:  if (w_accept) w_next = (rx_byte == r_csum) ? S_DONE : S_ERROR;
            S_DONE,
            S_ERROR:  if (start) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_pm_we    <= 1'b0;
            r_pm_addr  <= BASE_ADDR;
            r_pm_wdata <= '0;
            r_count    <= '0;
            r_word_cnt <= '0;
            r_csum     <= CHECKSUM_INIT;
        end else begin
            r_state    <= w_next;
            r_rx_ready <= (w_next != S_DONE) && (w_next != S_ERROR);
            r_pm_we    <= w_word_valid;
            if (w_word_valid) begin
                r_pm_addr  <= BASE_ADDR + ADDR_W'(r_word_cnt);
                r_pm_wdata <= w_word;
                r_word_cnt <= r_word_cnt + 16'd1;
            end
            if (w_accept && r_state == S_LEN_LO) r_count[7:0]  <= rx_byte;
            if (w_accept && r_state == S_LEN_HI) r_count[15:8] <= rx_byte;
            if (w_accept && r_state == S_DATA)   r_csum        <= r_csum ^ rx_byte;
            // Re-arming restarts addressing and the checksum for the next frame.
            if (w_rearm) begin
                r_pm_addr  <= BASE_ADDR;
                r_word_cnt <= '0;
                r_csum     <= CHECKSUM_INIT;
            end
        end
    end

    assign rx_ready = r_rx_ready;
    assign pm_we    = r_pm_we;
    assign pm_addr  = r_pm_addr;
    assign pm_wdata = r_pm_wdata;
    assign cpu_hold = (r_state != S_DONE);
    assign done     = (r_state == S_DONE);
    assign error    = (r_state == S_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        pm_we;
    logic [15:0] pm_addr;
    logic [31:0] pm_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wide_we = 0;
    logic        prev_we = 1'b0;

    prog_loader dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .pm_we    (pm_we),
        .pm_addr  (pm_addr),
        .pm_wdata (pm_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    // Write log sampled mid-cycle; back-to-back strobes are counted as too wide.
    always @(negedge clock) begin
        if (pm_we) begin
            wr_addr.push_back(pm_addr);
            wr_data.push_back(pm_wdata);
            if (prev_we) wide_we++;
        end
        prev_we = pm_we;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wide_we = 0;
    endtask

    function automatic logic [15:0] log_addr(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : 16'hxxxx;
    endfunction

    function automatic logic [31:0] log_data(input int i);
        return (i < wr_data.size()) ? wr_data[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_byte  = b;
        while (!rx_ready && n < 16) begin
            @(posedge clock); #1;
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", 64'(rx_ready), 64'd1);
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] q[$], input int max_gap);
        foreach (q[i]) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clock);
            #0 send_byte(q[i]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic expect_frame1(input string tag);
        check({tag, "_wr_count"}, 64'(wr_addr.size()), 64'd2);
        check({tag, "_wr0_addr"}, 64'(log_addr(0)), 64'h0000);
        check({tag, "_wr0_data"}, 64'(log_data(0)), 64'h1234_5678);
        check({tag, "_wr1_addr"}, 64'(log_addr(1)), 64'h0001);
        check({tag, "_wr1_data"}, 64'(log_data(1)), 64'hDEAD_BEEF);
        check({tag, "_we_width"}, 64'(wide_we), 64'd0);
    endtask

    logic [7:0] frame1[$]  = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    logic [7:0] frame_bad[$] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
    logic [7:0] partial[$] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
    logic [7:0] garbage[$] = '{8'h00, 8'hFF, 8'h5A};
    logic [7:0] oversize[$] = '{8'hA5, 8'h01, 8'h04};
    logic [7:0] zero_len[$] = '{8'hA5, 8'h00, 8'h00, 8'h00};
    logic [7:0] no_magic[$] = '{8'h00, 8'h00, 8'h00};

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_pm_we",    64'(pm_we),    64'd0);
        check("rst_pm_addr",  64'(pm_addr),  64'h0000);
        check("rst_pm_wdata", 64'(pm_wdata), 64'h0);
        check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        check("rst_done",     64'(done),     64'd0);
        check("rst_error",    64'(error),    64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_rx_ready", 64'(rx_ready), 64'd1);

        // 1: two-word frame, back-to-back
        clear_log();
        send_frame(frame1, 0);
        expect_frame1("s1");
        check("s1_done",      64'(done),     64'd1);
        check("s1_cpu_hold",  64'(cpu_hold), 64'd0);
        check("s1_rx_ready",  64'(rx_ready), 64'd0);
        check("s1_addr_hold", 64'(pm_addr),  64'h0001);
        check("s1_data_hold", 64'(pm_wdata), 64'hDEAD_BEEF);
        pulse_start();
        check("s1_start_done", 64'(done),     64'd0);
        check("s1_start_hold", 64'(cpu_hold), 64'd1);
        check("s1_start_addr", 64'(pm_addr),  64'h0000);
        check("s1_start_rdy",  64'(rx_ready), 64'd1);

        // 2: bad checksum
        clear_log();
        send_frame(frame_bad, 0);
        expect_frame1("s2");
        check("s2_error",    64'(error),    64'd1);
        check("s2_done",     64'(done),     64'd0);
        check("s2_cpu_hold", 64'(cpu_hold), 64'd1);
        check("s2_rx_ready", 64'(rx_ready), 64'd0);
        pulse_start();
        check("s2_start_error", 64'(error),    64'd0);
        check("s2_start_rdy",   64'(rx_ready), 64'd1);

        // 3: garbage then frame 1 with random gaps
        clear_log();
        send_frame(garbage, 0);
        check("s3_garbage_writes", 64'(wr_addr.size()), 64'd0);
        send_frame(frame1, 3);
        expect_frame1("s3");
        check("s3_done",     64'(done),     64'd1);
        check("s3_cpu_hold", 64'(cpu_hold), 64'd0);
        // start with a simultaneous byte: the MAGIC must not be taken
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'hA5;
        @(posedge clock); #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        check("s3_rearm_done", 64'(done), 64'd0);
        send_frame(no_magic, 0);
        check("s3_magic_dropped", 64'(done), 64'd0);

        // 4: oversized count
        clear_log();
        send_frame(oversize, 0);
        check("s4_error",    64'(error),    64'd1);
        check("s4_rx_ready", 64'(rx_ready), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check("s4_writes", 64'(wr_addr.size()), 64'd0);
        pulse_start();

        // 5: zero-length frame
        clear_log();
        send_frame(zero_len, 0);
        check("s5_writes",   64'(wr_addr.size()), 64'd0);
        check("s5_done",     64'(done),     64'd1);
        check("s5_cpu_hold", 64'(cpu_hold), 64'd0);
        pulse_start();

        // 6: reset after five payload bytes, then resend
        clear_log();
        send_frame(partial, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("s6_wr_count", 64'(wr_addr.size()), 64'd1);
        check("s6_wr0_addr", 64'(log_addr(0)), 64'h0000);
        check("s6_wr0_data", 64'(log_data(0)), 64'h1234_5678);
        check("s6_rst_addr", 64'(pm_addr),  64'h0000);
        check("s6_rst_hold", 64'(cpu_hold), 64'd1);
        check("s6_rst_rdy",  64'(rx_ready), 64'd0);
        repeat (4) @(posedge clock);
        #1;
        check("s6_no_spurious", 64'(wr_addr.size()), 64'd1);
        clear_log();
        send_frame(frame1, 0);
        expect_frame1("s6");
        check("s6_done",     64'(done),     64'd1);
        check("s6_cpu_hold", 64'(cpu_hold), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Serial program loader that writes the ToyRISC program memory. The CPU core only reads program memory; this block is the writer side. It accepts a framed byte stream from a serial front end, packs bytes into 32-bit instructions and writes them sequentially into program memory. It holds the CPU in reset until a frame has loaded and its checksum has passed.

Parameters:
ADDR_W, 16, program memory address width; matches instrAddr.
DATA_W, 32, instruction width. Fixed at 4 bytes.
DEPTH, 1024, maximum number of words a frame may load.
BASE_ADDR, 16'h0000, address of the first word written.
MAGIC, 8'hA5, frame start byte.

Ports:
clock  in  1  system clock; all logic is rising-edge.
reset  in  1  synchronous, active-high.
start  in  1  one-cycle pulse that re-arms the loader from DONE or ERROR.
rx_valid  in  1  rx_byte is valid.
rx_byte  in  8  incoming byte.
rx_ready  out  1  loader can accept a byte. A byte transfers when rx_valid && rx_ready.
pm_we  out  1  program memory write strobe, one cycle per word.
pm_addr  out  ADDR_W  program memory write address.
pm_wdata  out  DATA_W  program memory write data.
cpu_hold  out  1  drives the CPU reset; high means the CPU is held.
done  out  1  frame loaded and checksum good; sticky.
error  out  1  frame rejected; sticky.

Behaviour:
- Reset values: state IDLE; rx_ready=0, pm_we=0, pm_addr=BASE_ADDR, pm_wdata=0, cpu_hold=1, done=0, error=0.
- rx_ready is registered. It is 1 in IDLE, LEN_LO, LEN_HI, DATA and CHECK, and 0 in DONE and ERROR.
- Frame format: MAGIC, count[7:0], count[15:8], then count×4 payload bytes, then one checksum byte.
  - Payload words are little-endian.
  - Checksum is the XOR of all payload bytes. A count of 0 expects a checksum of 8'h00.
- State transitions (one per accepted byte):
  - IDLE: MAGIC → LEN_LO. Any other byte is discarded and the state stays IDLE.
  - LEN_LO → LEN_HI.
  - LEN_HI: count==0 → CHECK; count>DEPTH → ERROR; otherwise → DATA.
  - DATA: after the 4th byte of the final word → CHECK.
  - CHECK: checksum match → DONE; mismatch → ERROR.
- Write timing:
  - The cycle after the 4th byte of a word is accepted: pm_we=1 for exactly one cycle, with pm_wdata={b3,b2,b1,b0}.
  - pm_addr=BASE_ADDR+word_index, with word_index starting at 0.
  - pm_addr and pm_wdata hold their values until the next write.
  - There is never backpressure in DATA; back-to-back bytes are accepted every cycle.
- Gaps: rx_valid may drop at any point. State, the partial word and the running checksum hold.
- Address arithmetic is modulo 2^ADDR_W. BASE_ADDR+DEPTH ≤ 2^ADDR_W is a configuration requirement, so no wrap occurs in legal use.
- DONE: cpu_hold=0 from the cycle after the checksum byte is accepted; done=1 in the same cycle.
- ERROR: error=1 and cpu_hold stays 1. Words already written are not undone.
- start:
  - In DONE or ERROR, start → IDLE on the next cycle. done, error and the checksum clear; cpu_hold=1; pm_addr returns to BASE_ADDR.
  - start in any other state is ignored.
- Reset mid-frame aborts immediately. A pm_we pending for the next cycle is suppressed. All reset values apply.
- If rx_valid and start arrive in the same cycle while in DONE or ERROR, the byte is not accepted (rx_ready=0).

Decomposition:
- prog_loader_pkg holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR);
  - the MAGIC default;
  - BYTES_PER_WORD=4;
  - the CHECKSUM_INIT=8'h00 constant.
- Sub-module byte_packer: a 2-bit byte counter plus a shift register.
  - Ports: clock, reset, clear, in_valid, in_byte, word_valid (one-cycle pulse), word.
- The FSM, checksum, address counter and word counter stay in prog_loader.

Test Plan:
1. Two-word load: A5 02 00 78 56 34 12 EF BE AD DE 2A, streamed back-to-back.
   - Required: writes 0x12345678@0x0000 and 0xDEADBEEF@0x0001.
   - Each pm_we is exactly one cycle wide.
   - Then done=1 and cpu_hold=0 the cycle after 2A is accepted.
2. Same frame with checksum 2B.
   - Required: both writes still occur; error=1, cpu_hold=1, rx_ready=0.
   - After a start pulse: IDLE, error=0, rx_ready=1.
3. Garbage 00 FF 5A, then frame 1 with random rx_valid gaps of 0–3 cycles.
   - Required: garbage is ignored; writes and the final status are identical to scenario 1.
4. Oversized count A5 01 04 (count 1025 > DEPTH).
   - Required: ERROR right after the 3rd byte; pm_we never asserts.
5. Zero-length frame A5 00 00 00.
   - Required: no writes; done=1, cpu_hold=0.
6. Reset asserted after 5 payload bytes of frame 1.
   - Required: one write occurred (0x12345678@0x0000); reset values apply and no spurious pm_we follows.
   - Frame 1 resent afterwards loads correctly.
